// File: rtl/core_pkg.sv
// Shared core definitions: reset fetch address, instruction width and the
// fetch-unit state encoding.
package core_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          INST_W   = 32;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } ifu_state_t;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem request, hands {pc, inst} to
// decode, and squashes in-flight fetches on execute redirects.
module ifu
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  output logic [31:0]       next_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [INST_W-1:0] if_inst
);

  ifu_state_t        state_q;
  logic [31:0]       fetch_pc_q;
  logic [INST_W-1:0] inst_q;
  logic              req_hs;
  logic [31:0]       redirect_tgt;

  assign redirect_tgt   = redirect_pc & ~32'd3;
  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // Both outputs decode only the registered state, never if_ready/redirect.
  assign if_valid = (state_q == S_HOLD) && !rst;
  assign if_pc    = fetch_pc_q;
  assign if_inst  = inst_q;

  always_comb begin
    next_pc = pc;
    if (rst)                 next_pc = RESET_PC;
    else if (redirect_valid) next_pc = redirect_tgt;
    else if (req_hs)         next_pc = pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= '0;
      inst_q     <= '0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_hs) begin
            fetch_pc_q <= pc;
            state_q    <= redirect_valid ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (!redirect_valid) begin
              inst_q  <= imem_rsp_data;
              state_q <= S_HOLD;
            end else begin
              state_q <= S_REQ;
            end
          end else if (redirect_valid) begin
            state_q <= S_DROP;
          end
        end
        S_HOLD: begin
          if (redirect_valid || if_ready) state_q <= S_REQ;
        end
        S_DROP: begin
          // The stale response retires the only outstanding request; a
          // redirect here has already been folded into next_pc.
          if (imem_rsp_valid) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed vector table, a reset-during-fetch sequence and a
// randomized run scored against an instruction-stream model.
module tb_ifu;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .next_pc        (next_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  // PC register as it sits in the core top.
  always @(posedge clk) pc <= next_pc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory returns the word for the last accepted address.
  logic [31:0] hs_addr;
  always @(posedge clk) if (imem_req_valid && imem_req_ready) hs_addr <= imem_req_addr;
  assign imem_rsp_data = mem(hs_addr);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rsp, input logic ird,
                       input logic rv, input logic [31:0] rpc);
    rst = r; imem_req_ready = rdy; imem_rsp_valid = rsp;
    if_ready = ird; redirect_valid = rv; redirect_pc = rpc;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        r, rdy, rsp, ird, rv;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr, enpc;
    logic        eifv;
    logic [31:0] eifpc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic rdy, logic rsp, logic ird, logic rv, logic [31:0] rpc,
                              logic ereq, logic [31:0] eaddr, logic [31:0] enpc,
                              logic eifv, logic [31:0] eifpc);
    vec_t v;
    v.r = r; v.rdy = rdy; v.rsp = rsp; v.ird = ird; v.rv = rv; v.rpc = rpc;
    v.ereq = ereq; v.eaddr = eaddr; v.enpc = enpc; v.eifv = eifv; v.eifpc = eifpc;
    return v;
  endfunction

  task automatic check_cycle(input string tag, input logic ereq, input logic [31:0] eaddr,
                             input logic [31:0] enpc, input logic eifv, input logic [31:0] eifpc);
    chk({tag, " req_valid"}, {31'd0, imem_req_valid}, {31'd0, ereq});
    if (ereq) chk({tag, " req_addr"}, imem_req_addr, eaddr);
    chk({tag, " next_pc"}, next_pc, enpc);
    chk({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, eifv});
    if (eifv) begin
      chk({tag, " if_pc"}, if_pc, eifpc);
      chk({tag, " if_inst"}, if_inst, mem(eifpc));
    end
  endtask

  logic        pend, hs, rv_r, prev_hold;
  logic [31:0] rpc_r, model_pc, exp_npc, prev_pc, prev_inst;
  int          cnt, accepts;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    chk("rst fetch_pc", if_pc, 32'd0);
    chk("rst inst", if_inst, 32'd0);

    tbl.push_back(mk(1,0,0,0,0,0,             0,0,RESET_PC,0,0));
    // Zero-wait imem, three sequential fetches.
    tbl.push_back(mk(0,1,0,1,0,0,             1,32'h8000_0000,32'h8000_0004,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,             0,0,32'h8000_0004,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,             0,0,32'h8000_0004,1,32'h8000_0000));
    tbl.push_back(mk(0,1,0,1,0,0,             1,32'h8000_0004,32'h8000_0008,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,             0,0,32'h8000_0008,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,             0,0,32'h8000_0008,1,32'h8000_0004));
    tbl.push_back(mk(0,1,0,1,0,0,             1,32'h8000_0008,32'h8000_000C,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,             0,0,32'h8000_000C,0,0));
    // Decode backpressure for five cycles.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,1,0,0,0,0,           0,0,32'h8000_000C,1,32'h8000_0008));
    tbl.push_back(mk(0,1,0,1,0,0,             0,0,32'h8000_000C,1,32'h8000_0008));
    // Redirect in S_WAIT, stale response dropped.
    tbl.push_back(mk(0,1,0,1,0,0,             1,32'h8000_000C,32'h8000_0010,0,0));
    tbl.push_back(mk(0,1,0,1,1,32'h8000_0102, 0,0,32'h8000_0100,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,             0,0,32'h8000_0100,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,             1,32'h8000_0100,32'h8000_0100,0,0));
    // Redirect together with a request handshake.
    tbl.push_back(mk(0,1,0,1,1,32'h8000_0200, 1,32'h8000_0100,32'h8000_0200,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,             0,0,32'h8000_0200,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,             0,0,32'h8000_0200,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,             1,32'h8000_0200,32'h8000_0204,0,0));
    // Redirect together with the response.
    tbl.push_back(mk(0,1,1,1,1,32'h8000_0300, 0,0,32'h8000_0300,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,             1,32'h8000_0300,32'h8000_0304,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,             0,0,32'h8000_0304,0,0));
    // Redirect in S_HOLD while decode is ready: instruction dropped.
    tbl.push_back(mk(0,1,0,1,1,32'h8000_0400, 0,0,32'h8000_0400,1,32'h8000_0300));
    tbl.push_back(mk(0,0,0,1,0,0,             1,32'h8000_0400,32'h8000_0400,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,             1,32'h8000_0400,32'h8000_0404,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,             0,0,32'h8000_0404,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,             0,0,32'h8000_0404,1,32'h8000_0400));
    // Wrap-around at the top of the address space.
    tbl.push_back(mk(0,0,0,1,1,32'hFFFF_FFFF, 1,32'h8000_0404,32'hFFFF_FFFC,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,             1,32'hFFFF_FFFC,32'h0000_0000,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,             0,0,32'h0000_0000,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,             0,0,32'h0000_0000,1,32'hFFFF_FFFC));
    tbl.push_back(mk(0,1,0,1,0,0,             1,32'h0000_0000,32'h0000_0004,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].rdy, tbl[i].rsp, tbl[i].ird, tbl[i].rv, tbl[i].rpc);
      #1;
      check_cycle($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].enpc,
                  tbl[i].eifv, tbl[i].eifpc);
      tick();
    end

    // Reset while in S_WAIT, then the late response arrives and must be ignored.
    drive(1, 0, 0, 0, 0, 32'd0); #1;
    check_cycle("rstwait", 1'b0, 32'd0, RESET_PC, 1'b0, 32'd0);
    tick();
    drive(0, 0, 1, 1, 0, 32'd0); #1;
    check_cycle("late_rsp", 1'b1, RESET_PC, RESET_PC, 1'b0, 32'd0);
    tick();
    drive(0, 0, 0, 1, 0, 32'd0); #1;
    check_cycle("after_late", 1'b1, RESET_PC, RESET_PC, 1'b0, 32'd0);
    tick();
    drive(0, 1, 0, 1, 0, 32'd0); #1;
    check_cycle("restart_req", 1'b1, RESET_PC, RESET_PC + 32'd4, 1'b0, 32'd0);
    tick();
    drive(0, 1, 1, 1, 0, 32'd0); #1;
    check_cycle("restart_rsp", 1'b0, 32'd0, RESET_PC + 32'd4, 1'b0, 32'd0);
    tick();
    drive(0, 1, 0, 1, 0, 32'd0); #1;
    check_cycle("restart_hold", 1'b0, 32'd0, RESET_PC + 32'd4, 1'b1, RESET_PC);
    tick();

    // Randomized run: delivered instructions must form the sequential stream
    // starting at the latest redirect target.
    pend = 1'b0; cnt = 0; accepts = 0; prev_hold = 1'b0;
    model_pc = 32'd0; prev_pc = 32'd0; prev_inst = 32'd0;
    for (int c = 0; c < 4000; c++) begin
      rv_r  = (c == 0) || ($urandom_range(0, 11) == 0);
      rpc_r = (c == 0) ? 32'h8000_1000 : (32'h8000_0000 | ($urandom & 32'h0000_FFFF));
      drive(1'b0, ($urandom_range(0, 3) != 0), pend && (cnt == 0),
            ($urandom_range(0, 3) != 0), rv_r, rpc_r);
      #1;
      hs = imem_req_valid && imem_req_ready;
      if (imem_req_valid) chk("rnd req_addr", imem_req_addr, pc);
      if (hs) chk("rnd single_outstanding", {31'd0, pend}, 32'd0);
      exp_npc = rv_r ? (rpc_r & ~32'd3) : (hs ? pc + 32'd4 : pc);
      chk("rnd next_pc", next_pc, exp_npc);
      if (prev_hold) begin
        chk("rnd hold_valid", {31'd0, if_valid}, 32'd1);
        chk("rnd hold_pc", if_pc, prev_pc);
        chk("rnd hold_inst", if_inst, prev_inst);
      end
      if (if_valid && if_ready && !rv_r) begin
        chk("rnd deliver_pc", if_pc, model_pc);
        chk("rnd deliver_inst", if_inst, mem(model_pc));
        model_pc = model_pc + 32'd4;
        accepts++;
      end
      if (rv_r) model_pc = rpc_r & ~32'd3;
      prev_hold = if_valid && !if_ready && !rv_r;
      prev_pc   = if_pc;
      prev_inst = if_inst;
      if (imem_rsp_valid) pend = 1'b0;
      else if (pend && cnt > 0) cnt--;
      if (hs) begin
        pend = 1'b1;
        cnt  = $urandom_range(0, 3);
      end
      tick();
    end
    chk("rnd progress", {31'd0, (accepts > 100)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
